// File: rtl/j11bus_pkg.sv
// Shared definitions for the DCJ11 internal-bus responder: FSM states,
// I/O page decode, GP codes and interrupt priority helpers.
package j11bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEMWAIT,
    IOWAIT,
    RESP
  } state_e;

  localparam logic [8:0] IOPAGE_TOP = 9'h1FF;
  localparam logic [7:0] GP_PWRUP   = 8'o000;
  localparam logic [7:0] GP_CLRNXM  = 8'o377;

  // Highest pending level wins; bit3 is BR7.
  function automatic logic [8:0] irq_vector(input logic [3:0] lvl,
                                            input logic [8:0] v4,
                                            input logic [8:0] v5,
                                            input logic [8:0] v6,
                                            input logic [8:0] v7);
    logic [8:0] v;
    v = '0;
    if (lvl[3])      v = v7;
    else if (lvl[2]) v = v6;
    else if (lvl[1]) v = v5;
    else if (lvl[0]) v = v4;
    return v;
  endfunction

  function automatic logic [3:0] irq_grant(input logic [3:0] lvl);
    logic [3:0] g;
    g = '0;
    if (lvl[3])      g = 4'b1000;
    else if (lvl[2]) g = 4'b0100;
    else if (lvl[1]) g = 4'b0010;
    else if (lvl[0]) g = 4'b0001;
    return g;
  endfunction

endpackage

// File: rtl/j11bus_resp.sv
// Bus target for the DCJ11 front-end: one busack per busreq, decoding to
// memory, I/O page, GP codes or interrupt acknowledge, with NXM timeout.
module j11bus_resp
  import j11bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [15:0] PUCODE  = 16'o000001,
  parameter logic [8:0]  VEC4    = 9'o060,
  parameter logic [8:0]  VEC5    = 9'o064,
  parameter logic [8:0]  VEC6    = 9'o100,
  parameter logic [8:0]  VEC7    = 9'o104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busreq,
  input  logic        buswr,
  input  logic        busgp,
  input  logic        busirq,
  input  logic [21:0] busaddr,
  input  logic [15:0] buswdata,
  output logic        busack,
  output logic [15:0] busrdata,
  output logic        memreq,
  output logic        memwr,
  output logic [21:0] memaddr,
  output logic [15:0] memwdata,
  input  logic        memack,
  input  logic [15:0] memrdata,
  output logic        ioreq,
  output logic        iowr,
  output logic [12:0] ioaddr,
  output logic [15:0] iowdata,
  input  logic        ioack,
  input  logic [15:0] iordata,
  input  logic [3:0]  irqlvl,
  output logic [3:0]  irqgnt,
  output logic        nxm,
  output logic [21:0] nxmaddr
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_e      state_q;
  logic [21:0] addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic [15:0] cnt_q;
  logic        busack_q;
  logic [15:0] rdata_q;
  logic        memreq_q;
  logic        ioreq_q;
  logic [3:0]  irqgnt_q;
  logic        nxm_q;
  logic [21:0] nxmaddr_q;

  logic        wait_ack;
  logic [15:0] wait_data;

  assign wait_ack  = (state_q == MEMWAIT) ? memack   : ioack;
  assign wait_data = (state_q == MEMWAIT) ? memrdata : iordata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      busack_q  <= 1'b0;
      rdata_q   <= '0;
      memreq_q  <= 1'b0;
      ioreq_q   <= 1'b0;
      irqgnt_q  <= '0;
      nxm_q     <= 1'b0;
      nxmaddr_q <= '0;
    end else begin
      // Strobes default low; read data is only meaningful alongside busack.
      busack_q <= 1'b0;
      rdata_q  <= '0;
      irqgnt_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (busreq) begin
            addr_q  <= busaddr;
            wdata_q <= buswdata;
            wr_q    <= buswr;
            if (busirq) begin
              state_q  <= RESP;
              busack_q <= 1'b1;
              rdata_q  <= {7'b0, irq_vector(irqlvl, VEC4, VEC5, VEC6, VEC7)};
              irqgnt_q <= irq_grant(irqlvl);
            end else if (busgp) begin
              state_q  <= RESP;
              busack_q <= 1'b1;
              if (!buswr && busaddr[7:0] == GP_PWRUP) rdata_q <= PUCODE;
              if (buswr && busaddr[7:0] == GP_CLRNXM) nxm_q <= 1'b0;
            end else if (busaddr[21:13] == IOPAGE_TOP) begin
              state_q <= IOWAIT;
              ioreq_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q  <= MEMWAIT;
              memreq_q <= 1'b1;
              cnt_q    <= '0;
            end
          end
        end
        MEMWAIT, IOWAIT: begin
          // An ack in the timeout cycle itself still completes normally.
          if (wait_ack) begin
            state_q  <= RESP;
            memreq_q <= 1'b0;
            ioreq_q  <= 1'b0;
            busack_q <= 1'b1;
            rdata_q  <= wr_q ? '0 : wait_data;
          end else if (cnt_q == TMO) begin
            state_q  <= RESP;
            memreq_q <= 1'b0;
            ioreq_q  <= 1'b0;
            busack_q <= 1'b1;
            nxm_q    <= 1'b1;
            if (!nxm_q) nxmaddr_q <= addr_q;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busack   = busack_q;
  assign busrdata = rdata_q;
  assign memreq   = memreq_q;
  assign memwr    = memreq_q & wr_q;
  assign memaddr  = addr_q;
  assign memwdata = wdata_q;
  assign ioreq    = ioreq_q;
  assign iowr     = ioreq_q & wr_q;
  assign ioaddr   = addr_q[12:0];
  assign iowdata  = wdata_q;
  assign irqgnt   = irqgnt_q;
  assign nxm      = nxm_q;
  assign nxmaddr  = nxmaddr_q;

endmodule

// File: tb/tb_j11bus_resp.sv
// Directed bench for j11bus_resp: expected read data queued at request
// time and checked when busack appears.
module tb_j11bus_resp;

  logic        clk;
  logic        rst;
  logic        busreq, buswr, busgp, busirq;
  logic [21:0] busaddr;
  logic [15:0] buswdata;
  logic        busack;
  logic [15:0] busrdata;
  logic        memreq, memwr;
  logic [21:0] memaddr;
  logic [15:0] memwdata;
  logic        memack;
  logic [15:0] memrdata;
  logic        ioreq, iowr;
  logic [12:0] ioaddr;
  logic [15:0] iowdata;
  logic        ioack;
  logic [15:0] iordata;
  logic [3:0]  irqlvl;
  logic [3:0]  irqgnt;
  logic        nxm;
  logic [21:0] nxmaddr;

  int n_cmp = 0;
  int n_bad = 0;
  int n_push = 0;
  int ack_cnt = 0;
  int a0;
  logic [15:0] exp_q[$];

  j11bus_resp #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .busreq(busreq), .buswr(buswr), .busgp(busgp), .busirq(busirq),
    .busaddr(busaddr), .buswdata(buswdata),
    .busack(busack), .busrdata(busrdata),
    .memreq(memreq), .memwr(memwr), .memaddr(memaddr), .memwdata(memwdata),
    .memack(memack), .memrdata(memrdata),
    .ioreq(ioreq), .iowr(iowr), .ioaddr(ioaddr), .iowdata(iowdata),
    .ioack(ioack), .iordata(iordata),
    .irqlvl(irqlvl), .irqgnt(irqgnt),
    .nxm(nxm), .nxmaddr(nxmaddr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (busack) ack_cnt <= ack_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    exp_q.push_back(d);
    n_push++;
  endtask

  task automatic issue(input logic wr, input logic gp, input logic irq,
                       input logic [21:0] a, input logic [15:0] d);
    busreq = 1'b1; buswr = wr; busgp = gp; busirq = irq;
    busaddr = a; buswdata = d;
    tick();
    busreq = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int unsigned maxc);
    bit seen;
    logic [15:0] e;
    seen = 1'b0;
    for (int i = 0; i < int'(maxc) && !seen; i++) begin
      if (busack) begin
        seen = 1'b1;
        chk({tag, "_queued"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({tag, "_rdata"}, 32'(busrdata), 32'(e));
        end
        tick();
        chk({tag, "_ack_once"}, 32'(busack), 32'd0);
      end else begin
        tick();
      end
    end
    chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1; busreq = 1'b0; buswr = 1'b0; busgp = 1'b0; busirq = 1'b0;
    busaddr = '0; buswdata = '0; memack = 1'b0; memrdata = '0;
    ioack = 1'b0; iordata = '0; irqlvl = '0;
    repeat (3) tick();
    chk("rst_busack", 32'(busack), 32'd0);
    chk("rst_rdata", 32'(busrdata), 32'd0);
    chk("rst_memreq", 32'(memreq), 32'd0);
    chk("rst_ioreq", 32'(ioreq), 32'd0);
    chk("rst_irqgnt", 32'(irqgnt), 32'd0);
    chk("rst_nxm", 32'(nxm), 32'd0);
    chk("rst_nxmaddr", 32'(nxmaddr), 32'd0);
    rst = 1'b0;
    tick();

    // Memory read, zero wait states
    issue(1'b0, 1'b0, 1'b0, 22'o001000, 16'o0);
    push(16'o123456);
    chk("mr_memreq", 32'(memreq), 32'd1);
    chk("mr_memwr", 32'(memwr), 32'd0);
    chk("mr_memaddr", 32'(memaddr), 32'(22'o001000));
    chk("mr_ack_early", 32'(busack), 32'd0);
    memack = 1'b1; memrdata = 16'o123456;
    tick();
    memack = 1'b0;
    chk("mr_memreq_drop", 32'(memreq), 32'd0);
    chk("mr_ack_t2", 32'(busack), 32'd1);
    wait_ack("mr", 4);

    // I/O page write, ioack after 5 cycles
    issue(1'b1, 1'b0, 1'b0, 22'o17777560, 16'o000101);
    push(16'o0);
    chk("io_ioreq", 32'(ioreq), 32'd1);
    chk("io_iowr", 32'(iowr), 32'd1);
    chk("io_ioaddr", 32'(ioaddr), 32'(13'o17560));
    chk("io_iowdata", 32'(iowdata), 32'(16'o000101));
    chk("io_memreq", 32'(memreq), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("io_ioreq_hold", 32'(ioreq), 32'd1);
      chk("io_memreq_hold", 32'(memreq), 32'd0);
      chk("io_ack_early", 32'(busack), 32'd0);
    end
    ioack = 1'b1; iordata = 16'o177777;
    tick();
    ioack = 1'b0;
    chk("io_ack", 32'(busack), 32'd1);
    chk("io_ioreq_drop", 32'(ioreq), 32'd0);
    wait_ack("io", 4);

    // Interrupt acknowledge
    irqlvl = 4'b0110;
    issue(1'b0, 1'b0, 1'b1, 22'o0, 16'o0);
    push(16'o000100);
    chk("iack6_ack", 32'(busack), 32'd1);
    chk("iack6_gnt", 32'(irqgnt), 32'(4'b0100));
    wait_ack("iack6", 4);
    chk("iack6_gnt_pulse", 32'(irqgnt), 32'd0);
    irqlvl = 4'b1001;
    issue(1'b0, 1'b0, 1'b1, 22'o0, 16'o0);
    push(16'o000104);
    chk("iack7_gnt", 32'(irqgnt), 32'(4'b1000));
    wait_ack("iack7", 4);
    irqlvl = 4'b0000;
    issue(1'b0, 1'b0, 1'b1, 22'o0, 16'o0);
    push(16'o0);
    chk("iack0_gnt", 32'(irqgnt), 32'd0);
    wait_ack("iack0", 4);

    // NXM timeout (TIMEOUT=8): busack 10 cycles after busreq
    issue(1'b0, 1'b0, 1'b0, 22'o2000000, 16'o0);
    push(16'o0);
    chk("nxm_memreq", 32'(memreq), 32'd1);
    repeat (8) tick();
    chk("nxm_memreq_hold", 32'(memreq), 32'd1);
    chk("nxm_ack_early", 32'(busack), 32'd0);
    tick();
    chk("nxm_ack", 32'(busack), 32'd1);
    chk("nxm_memreq_drop", 32'(memreq), 32'd0);
    chk("nxm_flag", 32'(nxm), 32'd1);
    chk("nxm_addr", 32'(nxmaddr), 32'(22'o2000000));
    memack = 1'b1; memrdata = 16'o111111;
    wait_ack("nxm", 4);
    memack = 1'b0;
    tick();
    chk("nxm_late_ack", 32'(busack), 32'd0);

    issue(1'b0, 1'b0, 1'b0, 22'o3000000, 16'o0);
    push(16'o0);
    wait_ack("nxm2", 20);
    chk("nxm2_flag", 32'(nxm), 32'd1);
    chk("nxm2_addr_kept", 32'(nxmaddr), 32'(22'o2000000));

    issue(1'b1, 1'b1, 1'b0, 22'o000377, 16'o000007);
    push(16'o0);
    chk("gpclr_nxm", 32'(nxm), 32'd0);
    wait_ack("gpclr", 4);

    // GP reads; GP takes priority over I/O page decode
    issue(1'b0, 1'b1, 1'b0, 22'o0, 16'o0);
    push(16'o000001);
    chk("gp0_ack", 32'(busack), 32'd1);
    wait_ack("gp0", 4);
    issue(1'b0, 1'b1, 1'b0, 22'o000005, 16'o0);
    push(16'o0);
    wait_ack("gp5", 4);
    issue(1'b0, 1'b1, 1'b0, 22'o17777000, 16'o0);
    push(16'o000001);
    chk("gpio_ioreq", 32'(ioreq), 32'd0);
    wait_ack("gpio", 4);

    // Reset during MEMWAIT abandons the cycle
    issue(1'b0, 1'b0, 1'b0, 22'o004000, 16'o0);
    chk("rw_memreq", 32'(memreq), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_memreq_drop", 32'(memreq), 32'd0);
    chk("rw_noack", 32'(busack), 32'd0);
    a0 = ack_cnt;
    repeat (3) tick();
    chk("rw_noack_later", 32'(ack_cnt), 32'(a0));
    issue(1'b0, 1'b0, 1'b0, 22'o004000, 16'o0);
    push(16'o070707);
    tick();
    memack = 1'b1; memrdata = 16'o070707;
    tick();
    memack = 1'b0;
    wait_ack("rw_next", 4);

    // Ack in the same cycle as timeout wins
    issue(1'b0, 1'b0, 1'b0, 22'o005000, 16'o0);
    push(16'o055555);
    repeat (8) tick();
    chk("tie_ack_early", 32'(busack), 32'd0);
    memack = 1'b1; memrdata = 16'o055555;
    tick();
    memack = 1'b0;
    chk("tie_ack", 32'(busack), 32'd1);
    chk("tie_nxm", 32'(nxm), 32'd0);
    wait_ack("tie", 4);

    tick();
    chk("total_acks", 32'(ack_cnt), 32'(n_push));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
